instruction_fetch_unit: RTL and testbench
=========================================

// Module: instruction_fetch_unit
// PURPOSE
//   Initiator side of the instruction-memory fetch interface. Owns the PC,
//   drives the fetch address and samples the combinational instruction and
//   error return in the same cycle. Registers {pc, instr} into a one-entry
//   fetch buffer for decode. Handles stall, branch/jump redirect, and halt
//   on a memory fault.
// PARAMETERS
//   RESET_PC    64'h0   PC loaded on reset
//   XLEN        64      PC / address width
//   CNT_W       32      width of the retired-fetch counter
// PORTS
//   clk_i             in   1     clock, rising edge
//   rst_n_i           in   1     synchronous reset, active-low
//   imem_addr_o       out  XLEN  fetch byte address (= current PC)
//   imem_instr_i      in   32    instruction word at imem_addr_o, same cycle
//   imem_error_i      in   1     address out of range, same cycle
//   stall_i           in   1     decode not ready; hold buffer and PC
//   redirect_valid_i  in   1     taken branch/jump; load redirect_pc_i
//   redirect_pc_i     in   XLEN  redirect target
//   pc_o              out  XLEN  PC of buffered instruction
//   instr_o           out  32    buffered instruction
//   instr_valid_o     out  1     buffer holds a valid instruction
//   fetch_error_o     out  1     sticky fault flag (imem error or misaligned)
//   halted_o          out  1     FSM in HALT
//   fetch_count_o     out  CNT_W instructions accepted into buffer, saturating
// BEHAVIOUR
//   - Reset (rst_n_i=0 at posedge): PC=RESET_PC, state=RESET, pc_o=0,
//     instr_o=32'h0000_0013 (NOP), instr_valid_o=0, fetch_error_o=0,
//     halted_o=0, fetch_count_o=0. Reset overrides all inputs, any state.
//   - imem_addr_o = PC register, combinational; updates only on clock edges.
//   - FSM: RESET -> FETCH after one cycle (no fetch issued in RESET).
//     FETCH -> HALT on fault. HALT is terminal until reset.
//   - FETCH priority per cycle, highest first:
//     1. redirect_valid_i=1: if redirect_pc_i[1:0]!=0 -> fault. Else
//        PC<=redirect_pc_i, instr_valid_o<=0 (flush), counter unchanged.
//        Applies even when stall_i=1.
//     2. stall_i=1: PC, pc_o, instr_o, instr_valid_o, counter all held.
//     3. imem_error_i=1: fault; erroneous word never enters buffer.
//     4. else: pc_o<=PC, instr_o<=imem_instr_i, instr_valid_o<=1,
//        PC<=PC+4 (mod 2^XLEN, wraps to 0), counter +1 saturating at max.
//   - Fault: next cycle state=HALT, fetch_error_o=1, halted_o=1,
//     instr_valid_o=0; PC frozen at faulting address (redirect target if
//     misaligned), pc_o/instr_o hold last values.
//   - In HALT all inputs ignored; imem_addr_o constant.
//   - Latency: instruction at PC visible on instr_o one cycle after
//     imem_addr_o=PC, given no stall/redirect.
// STRUCTURE
//   - Shared package: fetch FSM state enum (RESET/FETCH/HALT), NOP encoding
//     32'h0000_0013, instruction-size constant 4.
//   - Single module; no sub-module. PC/next-PC logic, buffer and counter
//     inline. Optional sub-module sat_counter for fetch_count_o.
// TESTING
//   1. Reset, RESET_PC=0, memory holds 0x13,0x00100093,0x00200113 -> after
//      RESET cycle, instr_o sequence 0x13,0x00100093,0x00200113, pc_o 0,4,8.
//   2. stall_i=1 for 3 cycles while pc_o=4 -> pc_o/instr_o/count frozen;
//      release -> pc_o=8 next cycle, no instruction skipped or duplicated.
//   3. redirect_pc_i=0x20 at PC=0x8 -> next cycle instr_valid_o=0,
//      imem_addr_o=0x20; following cycle pc_o=0x20, count unchanged by flush.
//   4. redirect with stall_i=1 simultaneously -> redirect wins, buffer flushed.
//   5. imem_error_i=1 at PC=0x3FC -> fetch_error_o=1, halted_o=1,
//      instr_valid_o=0, imem_addr_o stays 0x3FC; later redirects ignored.
//   6. redirect_pc_i=0x22 -> HALT with fetch_error_o=1; rst_n_i=0 mid-HALT
//      -> all outputs to reset values next edge, fetch resumes at RESET_PC.

Source files
------------

// File: rtl/instruction_fetch_unit_pkg.sv
// Shared definitions for the instruction fetch unit: FSM states, the NOP
// encoding used as the empty-buffer value, and the fixed instruction size.
package instruction_fetch_unit_pkg;

  typedef enum logic [1:0] {
    ST_RESET = 2'd0,
    ST_FETCH = 2'd1,
    ST_HALT  = 2'd2
  } fetch_state_t;

  localparam logic [31:0] NOP_INSTR   = 32'h0000_0013;
  localparam int unsigned INSTR_BYTES = 4;

  // A fetch target must be word aligned; any set low bit is a fault.
  function automatic logic is_misaligned(input logic [1:0] addr_lsb);
    return addr_lsb != 2'b00;
  endfunction

endpackage

// File: rtl/instruction_fetch_unit_if.sv
// Fetch-side bundle: instruction-memory request/return, pipeline control
// from decode/execute, and the buffered instruction handed to decode.
interface instruction_fetch_unit_if #(
  parameter int unsigned XLEN  = 64,
  parameter int unsigned CNT_W = 32
) ();

  logic [XLEN-1:0]  imem_addr_o;
  logic [31:0]      imem_instr_i;
  logic             imem_error_i;
  logic             stall_i;
  logic             redirect_valid_i;
  logic [XLEN-1:0]  redirect_pc_i;
  logic [XLEN-1:0]  pc_o;
  logic [31:0]      instr_o;
  logic             instr_valid_o;
  logic             fetch_error_o;
  logic             halted_o;
  logic [CNT_W-1:0] fetch_count_o;

  // Fetch unit side: drives the memory address and the decode buffer.
  modport master (
    output imem_addr_o,
    input  imem_instr_i,
    input  imem_error_i,
    input  stall_i,
    input  redirect_valid_i,
    input  redirect_pc_i,
    output pc_o,
    output instr_o,
    output instr_valid_o,
    output fetch_error_o,
    output halted_o,
    output fetch_count_o
  );

  // Environment side: memory, decode and branch resolution.
  modport slave (
    input  imem_addr_o,
    output imem_instr_i,
    output imem_error_i,
    output stall_i,
    output redirect_valid_i,
    output redirect_pc_i,
    input  pc_o,
    input  instr_o,
    input  instr_valid_o,
    input  fetch_error_o,
    input  halted_o,
    input  fetch_count_o
  );

endinterface

// File: rtl/instruction_fetch_unit_sat_counter.sv
// Saturating up-counter: advances by one on inc and sticks at all-ones.
module instruction_fetch_unit_sat_counter #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             inc,
  output logic [WIDTH-1:0] count
);

  // Count accepted events, holding at the maximum instead of wrapping.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      count <= '0;
    end else if (inc && (count != '1)) begin
      count <= count + 1'b1;
    end
  end

endmodule

// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: owns the PC, issues a combinational fetch each
// FETCH cycle, captures {pc, instr} into a one-entry buffer for decode, and
// halts permanently (until reset) on a memory error or misaligned redirect.
module instruction_fetch_unit
  import instruction_fetch_unit_pkg::*;
#(
  parameter int unsigned     XLEN     = 64,
  parameter logic [XLEN-1:0] RESET_PC = '0,
  parameter int unsigned     CNT_W    = 32
) (
  input  logic                     clk_i,
  input  logic                     rst_n_i,
  instruction_fetch_unit_if.master bus
);

  fetch_state_t    state;
  fetch_state_t    state_next;
  logic [XLEN-1:0] pc;
  logic [XLEN-1:0] pc_next;
  logic [XLEN-1:0] pc_buf;
  logic [XLEN-1:0] pc_buf_next;
  logic [31:0]     instr_buf;
  logic [31:0]     instr_buf_next;
  logic            valid;
  logic            valid_next;
  logic            fault;
  logic            fault_next;
  logic            count_inc;

  // Next-state, next-PC and buffer update; redirect outranks stall, which
  // outranks a memory error, which outranks a normal fetch.
  always_comb begin
    state_next     = state;
    pc_next        = pc;
    pc_buf_next    = pc_buf;
    instr_buf_next = instr_buf;
    valid_next     = valid;
    fault_next     = fault;
    count_inc      = 1'b0;

    unique case (state)
      ST_RESET: begin
        state_next = ST_FETCH;
      end

      ST_FETCH: begin
        if (bus.redirect_valid_i) begin
          // A misaligned target still becomes the frozen PC so the fault
          // address is visible on imem_addr_o.
          pc_next    = bus.redirect_pc_i;
          valid_next = 1'b0;
          if (is_misaligned(bus.redirect_pc_i[1:0])) begin
            state_next = ST_HALT;
            fault_next = 1'b1;
          end
        end else if (bus.stall_i) begin
          // Decode not ready: everything holds.
          state_next = ST_FETCH;
        end else if (bus.imem_error_i) begin
          state_next = ST_HALT;
          fault_next = 1'b1;
          valid_next = 1'b0;
        end else begin
          pc_buf_next    = pc;
          instr_buf_next = bus.imem_instr_i;
          valid_next     = 1'b1;
          pc_next        = pc + XLEN'(INSTR_BYTES);
          count_inc      = 1'b1;
        end
      end

      ST_HALT: begin
        state_next = ST_HALT;
      end

      default: begin
        state_next = ST_RESET;
      end
    endcase
  end

  // State, PC and fetch-buffer registers with synchronous active-low reset.
  always_ff @(posedge clk_i) begin
    if (!rst_n_i) begin
      state     <= ST_RESET;
      pc        <= RESET_PC;
      pc_buf    <= '0;
      instr_buf <= NOP_INSTR;
      valid     <= 1'b0;
      fault     <= 1'b0;
    end else begin
      state     <= state_next;
      pc        <= pc_next;
      pc_buf    <= pc_buf_next;
      instr_buf <= instr_buf_next;
      valid     <= valid_next;
      fault     <= fault_next;
    end
  end

  instruction_fetch_unit_sat_counter #(
    .WIDTH (CNT_W)
  ) u_fetch_count (
    .clk   (clk_i),
    .rst_n (rst_n_i),
    .inc   (count_inc),
    .count (bus.fetch_count_o)
  );

  assign bus.imem_addr_o   = pc;
  assign bus.pc_o          = pc_buf;
  assign bus.instr_o       = instr_buf;
  assign bus.instr_valid_o = valid;
  assign bus.fetch_error_o = fault;
  assign bus.halted_o      = (state == ST_HALT);

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Self-checking bench for instruction_fetch_unit: directed scenarios followed
// by randomized stall/redirect/error/reset traffic, all compared every cycle
// against a cycle-level behavioural model of the fetch rules.
module tb_instruction_fetch_unit;

  localparam int unsigned XLEN  = 64;
  localparam int unsigned CNT_W = 4;

  logic clk = 1'b0;
  logic rst_n = 1'b0;

  always #5 clk = ~clk;

  logic            stall = 1'b0;
  logic            redir_v = 1'b0;
  logic [63:0]     redir_pc = '0;
  logic            err_on = 1'b0;
  logic [63:0]     err_addr = '0;
  logic            err_rand = 1'b0;

  instruction_fetch_unit_if #(.XLEN(XLEN), .CNT_W(CNT_W)) bus ();

  instruction_fetch_unit #(
    .XLEN     (XLEN),
    .RESET_PC (64'h0),
    .CNT_W    (CNT_W)
  ) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (bus)
  );

  // Instruction memory contents: three fixed words at the bottom, hashed
  // values elsewhere so every address returns a distinguishable word.
  function automatic logic [31:0] mem_word(input logic [63:0] a);
    case (a)
      64'h0:   return 32'h0000_0013;
      64'h4:   return 32'h0010_0093;
      64'h8:   return 32'h0020_0113;
      default: return (a[31:0] * 32'h9E37_79B1) ^ a[63:32];
    endcase
  endfunction

  assign bus.stall_i          = stall;
  assign bus.redirect_valid_i = redir_v;
  assign bus.redirect_pc_i    = redir_pc;
  assign bus.imem_instr_i     = mem_word(bus.imem_addr_o);
  assign bus.imem_error_i     = err_rand | (err_on && (bus.imem_addr_o == err_addr));

  // Reference model: mode 0 = waiting out reset, 1 = fetching, 2 = halted.
  int          m_mode = 0;
  logic [63:0] m_pc = '0;
  logic [63:0] m_pco = '0;
  logic [31:0] m_instr = 32'h13;
  logic        m_valid = 1'b0;
  logic        m_err = 1'b0;
  int unsigned m_cnt = 0;

  int vectors = 0;
  int miscompares = 0;

  task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
    vectors++;
    if (got !== exp) begin
      miscompares++;
      $display("FAIL %s: got %h expected %h (t=%0t)", tag, got, exp, $time);
    end
  endtask

  task automatic model_step();
    if (!rst_n) begin
      m_mode = 0; m_pc = '0; m_pco = '0; m_instr = 32'h13;
      m_valid = 1'b0; m_err = 1'b0; m_cnt = 0;
    end else if (m_mode == 0) begin
      m_mode = 1;
    end else if (m_mode == 1) begin
      if (redir_v) begin
        m_pc = redir_pc;
        m_valid = 1'b0;
        if (redir_pc % 4 != 0) begin
          m_mode = 2;
          m_err = 1'b1;
        end
      end else if (stall) begin
        // hold everything
      end else if (err_rand || (err_on && m_pc == err_addr)) begin
        m_mode = 2;
        m_err = 1'b1;
        m_valid = 1'b0;
      end else begin
        m_pco = m_pc;
        m_instr = mem_word(m_pc);
        m_valid = 1'b1;
        m_pc = m_pc + 64'd4;
        if (m_cnt < (1 << CNT_W) - 1) m_cnt++;
      end
    end
  endtask

  task automatic compare_all();
    check_eq("imem_addr", bus.imem_addr_o, m_pc);
    check_eq("pc_o", bus.pc_o, m_pco);
    check_eq("instr_o", 64'(bus.instr_o), 64'(m_instr));
    check_eq("instr_valid", 64'(bus.instr_valid_o), 64'(m_valid));
    check_eq("fetch_error", 64'(bus.fetch_error_o), 64'(m_err));
    check_eq("halted", 64'(bus.halted_o), 64'(m_mode == 2));
    check_eq("fetch_count", 64'(bus.fetch_count_o), 64'(m_cnt));
  endtask

  // One clock: advance the model with the inputs in force, then compare
  // just after the edge.
  task automatic tick();
    model_step();
    @(posedge clk);
    #1;
    compare_all();
  endtask

  int halt_cycles = 0;

  initial begin
    // Reset state
    rst_n = 1'b0;
    tick(); tick();
    check_eq("rst_instr_nop", 64'(bus.instr_o), 64'h13);
    check_eq("rst_valid", 64'(bus.instr_valid_o), 64'h0);
    rst_n = 1'b1;
    tick();
    check_eq("reset_cycle_no_fetch", 64'(bus.instr_valid_o), 64'h0);

    // Sequential fetch 0, 4
    tick();
    check_eq("seq_pc0", bus.pc_o, 64'h0);
    check_eq("seq_instr0", 64'(bus.instr_o), 64'h13);
    tick();
    check_eq("seq_pc4", bus.pc_o, 64'h4);
    check_eq("seq_instr4", 64'(bus.instr_o), 64'h0010_0093);

    // Stall three cycles at pc_o=4, then release
    stall = 1'b1;
    repeat (3) tick();
    check_eq("stall_pc_hold", bus.pc_o, 64'h4);
    check_eq("stall_cnt_hold", 64'(bus.fetch_count_o), 64'd2);
    stall = 1'b0;
    tick();
    check_eq("stall_release_pc8", bus.pc_o, 64'h8);
    check_eq("stall_release_instr8", 64'(bus.instr_o), 64'h0020_0113);

    // Redirect to 0x20
    redir_v = 1'b1; redir_pc = 64'h20;
    tick();
    check_eq("redir_flush", 64'(bus.instr_valid_o), 64'h0);
    check_eq("redir_addr", bus.imem_addr_o, 64'h20);
    check_eq("redir_cnt", 64'(bus.fetch_count_o), 64'd3);
    redir_v = 1'b0;
    tick();
    check_eq("redir_pc_o", bus.pc_o, 64'h20);

    // Redirect beats stall
    stall = 1'b1; redir_v = 1'b1; redir_pc = 64'h40;
    tick();
    check_eq("redir_stall_flush", 64'(bus.instr_valid_o), 64'h0);
    check_eq("redir_stall_addr", bus.imem_addr_o, 64'h40);
    stall = 1'b0; redir_v = 1'b0;

    // PC wrap at the top of the address space, then counter saturation
    redir_v = 1'b1; redir_pc = 64'hFFFF_FFFF_FFFF_FFFC;
    tick();
    redir_v = 1'b0;
    tick();
    check_eq("wrap_pc_o", bus.pc_o, 64'hFFFF_FFFF_FFFF_FFFC);
    check_eq("wrap_addr", bus.imem_addr_o, 64'h0);
    repeat (20) tick();
    check_eq("cnt_saturate", 64'(bus.fetch_count_o), 64'hF);

    // Memory error at 0x3FC halts; later redirects ignored
    err_on = 1'b1; err_addr = 64'h3FC;
    redir_v = 1'b1; redir_pc = 64'h3FC;
    tick();
    redir_v = 1'b0;
    tick();
    check_eq("err_halted", 64'(bus.halted_o), 64'h1);
    check_eq("err_flag", 64'(bus.fetch_error_o), 64'h1);
    check_eq("err_valid", 64'(bus.instr_valid_o), 64'h0);
    check_eq("err_addr_frozen", bus.imem_addr_o, 64'h3FC);
    redir_v = 1'b1; redir_pc = 64'h100;
    repeat (3) tick();
    check_eq("halt_ignores_redir", bus.imem_addr_o, 64'h3FC);
    redir_v = 1'b0; err_on = 1'b0;

    // Recover, then misaligned redirect, then reset mid-halt
    rst_n = 1'b0; tick();
    rst_n = 1'b1; tick(); tick(); tick();
    redir_v = 1'b1; redir_pc = 64'h22;
    tick();
    check_eq("misalign_halted", 64'(bus.halted_o), 64'h1);
    check_eq("misalign_err", 64'(bus.fetch_error_o), 64'h1);
    check_eq("misalign_addr", bus.imem_addr_o, 64'h22);
    redir_v = 1'b0;
    tick();
    rst_n = 1'b0;
    tick();
    check_eq("halt_rst_halted", 64'(bus.halted_o), 64'h0);
    check_eq("halt_rst_err", 64'(bus.fetch_error_o), 64'h0);
    check_eq("halt_rst_cnt", 64'(bus.fetch_count_o), 64'h0);
    check_eq("halt_rst_addr", bus.imem_addr_o, 64'h0);
    rst_n = 1'b1;
    tick(); tick();
    check_eq("resume_pc0", bus.pc_o, 64'h0);
    check_eq("resume_instr0", 64'(bus.instr_o), 64'h13);

    // Randomized traffic
    for (int i = 0; i < 400; i++) begin
      halt_cycles = (m_mode == 2) ? halt_cycles + 1 : 0;
      rst_n    = !(($urandom_range(0, 99) < 2) || (halt_cycles > 4));
      stall    = ($urandom_range(0, 99) < 25);
      redir_v  = ($urandom_range(0, 99) < 12);
      redir_pc = 64'($urandom_range(0, 255)) * 64'd4;
      if ($urandom_range(0, 99) < 15) redir_pc[1:0] = 2'($urandom_range(1, 3));
      if ($urandom_range(0, 99) < 5) redir_pc = {32'hFFFF_FFFF, $urandom} & ~64'h3;
      err_rand = ($urandom_range(0, 99) < 3);
      tick();
    end

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
